// File: rtl/soc_gpio_pad_ctrl.sv
// Pad-side GPIO responder: input synchronizer, per-bit glitch filter, sticky edge flags, irq.
// Build option SOC_GPIO_OUT_REG_EN registers the pad output path (default: combinational).
module soc_gpio_pad_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_dout,
    output logic [WIDTH-1:0] gpio_din,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    input  logic             filter_en,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_flags,
    output logic             irq
);

    localparam int CW = $clog2(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]                  sync;

    logic [WIDTH-1:0]         filt_q;
    logic [WIDTH-1:0]         filt_d;
    logic [WIDTH-1:0]         prev_q;
    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;

    logic [WIDTH-1:0] flags_q;
    logic [WIDTH-1:0] flags_d;
    logic             irq_q;
    logic             irq_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
    assign sync   = sync_q[SYNC_STAGES-1];

    // A bit only moves after CNT_MAX+1 consecutive evaluations of disagreement.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!filter_en) begin
                filt_d[i] = sync[i];
            end else if (sync[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    filt_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // prev_q lags filt_q by one cycle; set beats clear on collision.
    always_comb begin
        flags_d = (flags_q & ~edge_clear) | (filt_q ^ prev_q);
        irq_d   = |flags_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            irq_q   <= irq_d;
        end
    end

    assign gpio_din   = filt_q;
    assign edge_flags = flags_q;
    assign irq        = irq_q;

`ifdef SOC_GPIO_OUT_REG_EN
    logic [WIDTH-1:0] pad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_q <= '0;
        end else begin
            pad_q <= gpio_dout;
        end
    end

    assign pad_out = pad_q;
`else
    assign pad_out = gpio_dout;
`endif

endmodule

// File: tb/tb_soc_gpio_pad_ctrl.sv
// Directed bench for soc_gpio_pad_ctrl (SYNC_STAGES=2, FILTER_CYCLES=4).
// Honors SOC_GPIO_OUT_REG_EN for the output-path expectations.
module tb_soc_gpio_pad_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] gpio_dout;
    logic [31:0] gpio_din;
    logic [31:0] pad_in;
    logic [31:0] pad_out;
    logic        filter_en;
    logic [31:0] edge_clear;
    logic [31:0] edge_flags;
    logic        irq;

    int n_chk;
    int n_fail;

    soc_gpio_pad_ctrl #(
        .WIDTH(32),
        .SYNC_STAGES(2),
        .FILTER_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .gpio_dout(gpio_dout),
        .gpio_din(gpio_din),
        .pad_in(pad_in),
        .pad_out(pad_out),
        .filter_en(filter_en),
        .edge_clear(edge_clear),
        .edge_flags(edge_flags),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        pad_in     = 32'hFFFF_FFFF;
        filter_en  = 1'b0;
        edge_clear = '0;
        gpio_dout  = '0;

        // Reset and bypass
        tick(2);
        chk("rst_din", gpio_din, 32'h0);
        chk("rst_flags", edge_flags, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_pad_out", pad_out, 32'h0);
        rst_n = 1'b1;
        tick(2);
        chk("byp_din_early", gpio_din, 32'h0);
        tick(1);
        chk("byp_din_3cyc", gpio_din, 32'hFFFF_FFFF);
        chk("byp_flags_lag", edge_flags, 32'h0);
        tick(1);
        chk("byp_flags", edge_flags, 32'hFFFF_FFFF);
        chk("byp_irq", {31'b0, irq}, 32'h1);
        edge_clear = '1;
        tick(1);
        chk("clr_all_flags", edge_flags, 32'h0);
        chk("clr_all_irq", {31'b0, irq}, 32'h0);
        edge_clear = '0;
        pad_in     = '0;
        tick(4);
        chk("fall_din", gpio_din, 32'h0);
        chk("fall_flags", edge_flags, 32'hFFFF_FFFF);
        edge_clear = '1;
        tick(1);
        edge_clear = '0;
        chk("clr2_flags", edge_flags, 32'h0);

        // Glitch rejection
        filter_en = 1'b1;
        pad_in    = 32'h20;
        tick(3);
        pad_in = '0;
        tick(10);
        chk("glitch3_din", gpio_din, 32'h0);
        chk("glitch3_flags", edge_flags, 32'h0);
        pad_in = 32'h20;
        tick(5);
        pad_in = '0;
        chk("pulse5_din_early", gpio_din, 32'h0);
        tick(1);
        chk("pulse5_din_6cyc", gpio_din, 32'h20);
        chk("pulse5_flags_lag", edge_flags, 32'h0);
        tick(1);
        chk("pulse5_flags", edge_flags, 32'h20);
        chk("pulse5_irq", {31'b0, irq}, 32'h1);
        tick(10);
        chk("pulse5_din_back", gpio_din, 32'h0);
        chk("pulse5_sticky", edge_flags, 32'h20);
        edge_clear = '1;
        tick(1);
        edge_clear = '0;
        chk("clr3_flags", edge_flags, 32'h0);

        // Flag clear collision on bit 3
        filter_en = 1'b0;
        pad_in    = 32'h8;
        tick(3);
        chk("col_din_rise", gpio_din, 32'h8);
        pad_in = '0;
        tick(1);
        chk("col_flag_set", edge_flags, 32'h8);
        tick(2);
        chk("col_din_fall", gpio_din, 32'h0);
        edge_clear = 32'h8;
        tick(1);
        chk("col_set_wins", edge_flags, 32'h8);
        chk("col_irq_held", {31'b0, irq}, 32'h1);
        tick(1);
        chk("col_cleared", edge_flags, 32'h0);
        chk("col_irq_fall", {31'b0, irq}, 32'h0);
        edge_clear = '0;

        // Filter enable toggled mid-count
        filter_en = 1'b1;
        pad_in    = 32'h1;
        tick(4);
        chk("tog_din_pending", gpio_din, 32'h0);
        filter_en = 1'b0;
        tick(1);
        chk("tog_din_bypass", gpio_din, 32'h1);
        pad_in = '0;
        tick(2);
        filter_en = 1'b1;
        tick(3);
        chk("tog_din_hold3", gpio_din, 32'h1);
        tick(1);
        chk("tog_din_full4", gpio_din, 32'h0);
        tick(2);
        edge_clear = '1;
        tick(1);
        edge_clear = '0;
        chk("clr4_flags", edge_flags, 32'h0);

        // Independent bits
        filter_en = 1'b0;
        pad_in    = 32'h0000_0001;
        tick(1);
        pad_in = 32'h8000_0000;
        tick(2);
        chk("ind_din_w0", gpio_din, 32'h0000_0001);
        tick(1);
        chk("ind_din_w1", gpio_din, 32'h8000_0000);
        chk("ind_flags_b0", edge_flags, 32'h0000_0001);
        tick(1);
        chk("ind_flags", edge_flags, 32'h8000_0001);
        chk("ind_irq", {31'b0, irq}, 32'h1);

        // Output path
        gpio_dout = 32'hA5A5_5A5A;
        #1;
`ifdef SOC_GPIO_OUT_REG_EN
        chk("out_same_cyc", pad_out, 32'h0);
        tick(1);
        chk("out_next_cyc", pad_out, 32'hA5A5_5A5A);
`else
        chk("out_same_cyc", pad_out, 32'hA5A5_5A5A);
        tick(1);
        chk("out_next_cyc", pad_out, 32'hA5A5_5A5A);
`endif

        // Reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("rst2_din", gpio_din, 32'h0);
        chk("rst2_flags", edge_flags, 32'h0);
        chk("rst2_irq", {31'b0, irq}, 32'h0);
`ifdef SOC_GPIO_OUT_REG_EN
        chk("rst2_pad_out", pad_out, 32'h0);
`else
        chk("rst2_pad_out", pad_out, 32'hA5A5_5A5A);
`endif
        tick(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
